fde_exec_8bit: RTL

Phase-driven 8-bit instruction executor. It consumes the one-hot `fetch` / `decode` / `execute` strobes produced by the `fde_8bit` phase generator and acts on each one. On fetch it reads an opcode from program memory, on decode it decodes it, and on execute it updates the accumulator, flags and program counter. It sits directly downstream of the phase generator and upstream of an asynchronous program ROM, and closes the fetch-decode-execute loop of the ByteBlast core.

---
 rtl/fde_exec_8bit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fde_exec_8bit.sv
// Phase-driven 8-bit executor: acts on one-hot fetch/decode/execute strobes to run a tiny accumulator ISA.
// Build option: FDE_EXEC_ILLEGAL_TRAP_EN makes reserved opcodes A-E halt instead of acting as NOP.
module fde_exec_8bit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fetch,
    input  logic       decode,
    input  logic       execute,
    output logic [7:0] mem_adr,
    output logic       mem_rd,
    input  logic [7:0] mem_data,
    output logic [7:0] pc,
    output logic [7:0] acc,
    output logic       zf,
    output logic       cf,
    output logic       halted,
    output logic       phase_err
);

`ifdef FDE_EXEC_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
    typedef enum logic [1:0] {J_NONE, J_ALWAYS, J_ZERO, J_CARRY} jcond_t;

    state_t      state_q, state_d;
    jcond_t      jcond_q, jcond_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  acc_q, acc_d;
    logic        zf_q, zf_d;
    logic        cf_q, cf_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic        acc_we_q, acc_we_d;
    logic        halt_dec_q, halt_dec_d;

    logic [2:0]  strobes;
    logic [3:0]  op;
    logic [7:0]  imm8;
    logic [8:0]  sum9;
    logic [8:0]  diff9;
    logic [7:0]  alu_res;
    logic        carry_res;
    logic        taken;

    assign strobes = {fetch, decode, execute};
    assign op      = ir_q[7:4];
    assign imm8    = {4'h0, ir_q[3:0]};
    assign sum9    = {1'b0, acc_q} + {1'b0, imm8};
    assign diff9   = {1'b0, acc_q} - {1'b0, imm8};

    // ALU result and carry; ops that leave cf alone pass the old flag through
    always_comb begin
        alu_res   = acc_q;
        carry_res = cf_q;
        case (alu_op_q)
            3'd1: alu_res = imm8;
            3'd2: {carry_res, alu_res} = sum9;
            3'd3: {carry_res, alu_res} = diff9;
            3'd4: alu_res = acc_q & imm8;
            3'd5: alu_res = acc_q | imm8;
            3'd6: alu_res = acc_q ^ imm8;
            default: ;
        endcase
    end

    always_comb begin
        case (jcond_q)
            J_ALWAYS: taken = 1'b1;
            J_ZERO:   taken = zf_q;
            J_CARRY:  taken = cf_q;
            default:  taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        acc_d      = acc_q;
        zf_d       = zf_q;
        cf_d       = cf_q;
        halted_d   = halted_q;
        err_d      = err_q;
        alu_op_d   = alu_op_q;
        acc_we_d   = acc_we_q;
        jcond_d    = jcond_q;
        halt_dec_d = halt_dec_q;
        case (state_q)
            S_FETCH: begin
                if (strobes == 3'b100) begin
                    ir_d    = mem_data;
                    state_d = S_DECODE;
                end else if (strobes != 3'b000) begin
                    err_d = 1'b1;
                end
            end
            S_DECODE: begin
                if (strobes == 3'b010) begin
                    alu_op_d   = op[2:0];
                    acc_we_d   = (op >= 4'h1) && (op <= 4'h6);
                    case (op)
                        4'h7:    jcond_d = J_ALWAYS;
                        4'h8:    jcond_d = J_ZERO;
                        4'h9:    jcond_d = J_CARRY;
                        default: jcond_d = J_NONE;
                    endcase
                    halt_dec_d = (op == 4'hF) || (TRAP_EN && (op >= 4'hA) && (op <= 4'hE));
                    state_d    = S_EXEC;
                end else if (strobes != 3'b000) begin
                    err_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (strobes == 3'b001) begin
                    if (halt_dec_q) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        if (acc_we_q) begin
                            acc_d = alu_res;
                            zf_d  = (alu_res == 8'h00);
                            cf_d  = carry_res;
                        end
                        pc_d    = taken ? {ir_q[3:0], 4'h0} : pc_q + 8'd1;
                        state_d = S_FETCH;
                    end
                end else if (strobes != 3'b000) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            ir_q       <= 8'h00;
            pc_q       <= RESET_PC;
            acc_q      <= 8'h00;
            zf_q       <= 1'b0;
            cf_q       <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
            alu_op_q   <= 3'd0;
            acc_we_q   <= 1'b0;
            jcond_q    <= J_NONE;
            halt_dec_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            acc_q      <= acc_d;
            zf_q       <= zf_d;
            cf_q       <= cf_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
            alu_op_q   <= alu_op_d;
            acc_we_q   <= acc_we_d;
            jcond_q    <= jcond_d;
            halt_dec_q <= halt_dec_d;
        end
    end

    assign mem_adr   = pc_q;
    assign mem_rd    = fetch & (state_q == S_FETCH) & ~halted_q;
    assign pc        = pc_q;
    assign acc       = acc_q;
    assign zf        = zf_q;
    assign cf        = cf_q;
    assign halted    = halted_q;
    assign phase_err = err_q;

endmodule
